line_fill_assembler: RTL

Fill-side assembler for the read-only cache. It collects UNIT_WIDTH-wide memory beats into a LINE_WIDTH-wide cache line, writing each beat into one slot chosen by a rotating one-hot slot pointer. Fills can start at any slot (critical-word-first) and wrap around. The completed line is presented to the data array over a valid/ready handshake.

---
 rtl/line_fill_assembler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/line_fill_assembler.sv
// Line fill assembler: packs UNIT_WIDTH beats into a LINE_WIDTH cache line via a rotating one-hot slot pointer (critical-word-first, wrapping).
// Latency: line_valid one cycle after the Nth beat transfers; next fill can be accepted one cycle after line_ready.
// Backpressure: beat_ready only in FILL (dropped by fill_abort); line held in DONE until line_ready. Optional RO_CACHE_CRIT_WORD_FWD_EN enables crit-word pulse.
module line_fill_assembler #(
    parameter int LINE_WIDTH = 32,
    parameter int UNIT_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fill_start,
    input  logic [LINE_WIDTH/UNIT_WIDTH-1:0]  fill_sel,
    output logic                              fill_ready,
    input  logic                              fill_abort,
    input  logic                              beat_valid,
    input  logic [UNIT_WIDTH-1:0]             beat_data,
    output logic                              beat_ready,
    output logic                              line_valid,
    output logic [LINE_WIDTH-1:0]             line_data,
    input  logic                              line_ready,
    output logic                              crit_valid,
    output logic [UNIT_WIDTH-1:0]             crit_data
);

    localparam int N  = LINE_WIDTH / UNIT_WIDTH;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    line_valid_q, line_valid_d;
    logic                    fill_go;
    logic                    beat_go;
    logic [N-1:0]            sel_low;

    // Handshake decode from state, and the starting slot (lowest set bit, slot 0 when empty)
    always_comb begin
        fill_ready = (state_q == IDLE);
        beat_ready = (state_q == FILL) && !fill_abort;
        fill_go    = fill_start && fill_ready;
        beat_go    = beat_valid && beat_ready;
        sel_low    = fill_sel & (~fill_sel + N'(1));
        if (sel_low == '0) begin
            sel_low = N'(1);
        end
    end

    // Next-state logic: fill control, slot writes and pointer rotation
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (fill_go) begin
                    state_d = FILL;
                    line_d  = '0;
                    ptr_d   = sel_low;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                // Abort wins: beat_ready is already low, so no beat lands this cycle
                if (fill_abort) begin
                    state_d = IDLE;
                end else if (beat_go) begin
                    for (int k = 0; k < N; k++) begin
                        if (ptr_q[k]) begin
                            line_d[k*UNIT_WIDTH +: UNIT_WIDTH] = beat_data;
                        end
                    end
                    ptr_d = (ptr_q << 1) | (ptr_q >> (N - 1));
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (line_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        line_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign line_valid = line_valid_q;
    assign line_data  = line_q;

`ifdef RO_CACHE_CRIT_WORD_FWD_EN
    logic                  first_beat;
    logic                  crit_valid_q;
    logic [UNIT_WIDTH-1:0] crit_data_q;

    assign first_beat = beat_go && (cnt_q == '0);

    // One-cycle pulse with the first beat of each fill; data held until the next first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= first_beat;
            if (first_beat) begin
                crit_data_q <= beat_data;
            end
        end
    end

    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule
